bit_population_counter_pipe: RTL and testbench



---
 rtl/bit_population_counter_pipe_pkg.sv | 26 ++
 rtl/bit_population_counter_pipe_if.sv | 23 ++
 rtl/bit_population_counter_pipe_chunk.sv | 21 ++
 rtl/bit_population_counter_pipe.sv | 87 ++++++++
 tb/tb_bit_population_counter_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_population_counter_pipe_pkg.sv
// Sizing helpers and mode encoding shared by the pipelined population counter.
package popcnt_pkg;

    typedef enum logic {
        POP_ONES  = 1'b0,
        POP_ZEROS = 1'b1
    } pop_mode_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    function automatic int lat(input int width, input int chunk);
        return 1 + $clog2(nchunk(width, chunk));
    endfunction

    // Element count of adder-tree level lvl when level 0 holds n slices.
    function automatic int lvl_cnt(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/bit_population_counter_pipe_if.sv
// Word-in / count-out valid-ready bundle of the pipelined population counter.
interface bit_population_counter_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = popcnt_pkg::cnt_w(WIDTH)
);
    logic [WIDTH-1:0] data_i;
    logic             mode_i;
    logic             data_val_i;
    logic             data_ready_o;
    logic [CNT_W-1:0] data_o;
    logic             data_val_o;
    logic             data_ready_i;

    modport slave (
        input  data_i, mode_i, data_val_i, data_ready_i,
        output data_ready_o, data_o, data_val_o
    );

    modport master (
        output data_i, mode_i, data_val_i, data_ready_i,
        input  data_ready_o, data_o, data_val_o
    );
endinterface

// File: rtl/bit_population_counter_pipe_chunk.sv
// Combinational count of the set bits of one slice, restricted to its mask.
module popcnt_chunk
    import popcnt_pkg::*;
#(
    parameter  int CHUNK = 8,
    localparam int CW    = cnt_w(CHUNK)
) (
    input  logic [CHUNK-1:0] chunk_bits,
    input  logic [CHUNK-1:0] chunk_mask,
    output logic [CW-1:0]    chunk_cnt
);

    // Ripple accumulation over the slice; CHUNK is small so depth stays short.
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + CW'(chunk_bits[i] & chunk_mask[i]);
        end
    end

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Pipelined ones/zeros counter: per-slice counts feed a registered adder tree,
// the whole pipe advancing together under a single stall enable.
module bit_population_counter_pipe
    import popcnt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    bit_population_counter_pipe_if.slave bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int LAT    = lat(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_w(WIDTH);
    localparam int CW0    = cnt_w(CHUNK);
    localparam int PW     = NCHUNK * CHUNK;
    // Padding bits of the last slice are masked after inversion so they never count.
    localparam logic [PW-1:0] PAD_MASK = PW'({WIDTH{1'b1}});

    logic           adv_s;
    logic [LAT-1:0] vld_r;
    logic [PW-1:0]  pad_s;
    logic [PW-1:0]  eff_s;

    assign adv_s            = ~vld_r[LAT-1] | bus.data_ready_i;
    assign bus.data_ready_o = adv_s;
    assign bus.data_val_o   = vld_r[LAT-1];

    assign pad_s = PW'(bus.data_i);
    assign eff_s = (pop_mode_e'(bus.mode_i) == POP_ZEROS) ? ~pad_s : pad_s;

    // Valid shift chain; bubbles travel alongside data and are never collapsed.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            vld_r <= '0;
        end else if (adv_s) begin
            vld_r[0] <= bus.data_val_i;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    for (genvar l = 0; l < LAT; l++) begin : g_lvl
        localparam int N = lvl_cnt(NCHUNK, l);
        localparam int W = CW0 + l;

        logic [W-1:0] nxt_s [N];
        logic [W-1:0] sum_r [N];

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < N; k++) begin : g_chunk
                popcnt_chunk #(
                    .CHUNK (CHUNK)
                ) u_chunk (
                    .chunk_bits (eff_s[k*CHUNK +: CHUNK]),
                    .chunk_mask (PAD_MASK[k*CHUNK +: CHUNK]),
                    .chunk_cnt  (nxt_s[k])
                );
            end
        end else begin : g_sum
            localparam int NP = lvl_cnt(NCHUNK, l - 1);
            for (genvar i = 0; i < N; i++) begin : g_node
                if (2 * i + 1 < NP) begin : g_pair
                    assign nxt_s[i] = W'(g_lvl[l-1].sum_r[2*i]) + W'(g_lvl[l-1].sum_r[2*i+1]);
                end else begin : g_pass
                    assign nxt_s[i] = W'(g_lvl[l-1].sum_r[2*i]);
                end
            end
        end

        // Level register; cleared on reset so the output count reads zero.
        always_ff @(posedge clk_i or posedge srst_i) begin
            if (srst_i) begin
                sum_r <= '{default: '0};
            end else if (adv_s) begin
                sum_r <= nxt_s;
            end
        end
    end

    // The tree root is wide enough for WIDTH, so narrowing to CNT_W loses nothing.
    assign bus.data_o = CNT_W'(g_lvl[LAT-1].sum_r[0]);

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Bench for the pipelined population counter: 32/8 and 20/8 instances share one
// stimulus stream and are each compared every cycle against a latency-queue model.
module tb_bit_population_counter_pipe;

    localparam int LAT = 3;

    logic        clk  = 1'b0;
    logic        srst = 1'b1;
    logic [31:0] data = 32'd0;
    logic        mode = 1'b0;
    logic        val  = 1'b0;
    logic        rdy  = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int cyc   = 0;
    int e32, e20;
    int mq32[$] = '{-1, -1, -1};
    int mq20[$] = '{-1, -1, -1};
    int bub_v[4] = '{1, 0, 1, 0};
    int bub_d[4] = '{1, 0, 2, 0};

    bit_population_counter_pipe_if #(.WIDTH(32)) bus32 ();
    bit_population_counter_pipe_if #(.WIDTH(20)) bus20 ();

    assign bus32.data_i       = data;
    assign bus32.mode_i       = mode;
    assign bus32.data_val_i   = val;
    assign bus32.data_ready_i = rdy;
    assign bus20.data_i       = data[19:0];
    assign bus20.mode_i       = mode;
    assign bus20.data_val_i   = val;
    assign bus20.data_ready_i = rdy;

    bit_population_counter_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus32)
    );

    bit_population_counter_pipe #(.WIDTH(20), .CHUNK(8)) dut20 (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus20)
    );

    always #5 clk = ~clk;

    function automatic int pop(input logic [31:0] d, input logic m, input int w);
        logic [31:0] msk;
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return $countones((m ? ~d : d) & msk);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        val  = 1'b0;
        data = 'x;
        rdy  = 1'b1;
        repeat (n) step();
    endtask

    // Three back-to-back words, then the three results checked against literals.
    task automatic dir3(input logic [31:0] d0, input logic m0, input logic [31:0] d1,
                        input logic m1, input logic [31:0] d2, input logic m2,
                        input int a0, input int a1, input int a2,
                        input int b0, input int b1, input int b2);
        rdy = 1'b1;
        val = 1'b1;
        data = d0; mode = m0; step();
        data = d1; mode = m1; step();
        data = d2; mode = m2; step();
        val = 1'b0;
        data = 'x;
        @(negedge clk);
        chk("dir_val0", 32'(bus32.data_val_o), 32'd1);
        chk("dir32_0", 32'(bus32.data_o), 32'(a0));
        chk("dir20_0", 32'(bus20.data_o), 32'(b0));
        @(negedge clk);
        chk("dir32_1", 32'(bus32.data_o), 32'(a1));
        chk("dir20_1", 32'(bus20.data_o), 32'(b1));
        @(negedge clk);
        chk("dir32_2", 32'(bus32.data_o), 32'(a2));
        chk("dir20_2", 32'(bus20.data_o), 32'(b2));
    endtask

    // Reference: each accepted count reappears LAT advancing edges later, -1 marks a bubble.
    always @(posedge clk or posedge srst) begin
        if (srst) begin
            mq32 = '{-1, -1, -1};
            mq20 = '{-1, -1, -1};
        end else begin
            if (mq32[LAT-1] == -1 || rdy) begin
                if (val) n_acc++;
                mq32.push_front(val ? pop(data, mode, 32) : -1);
                void'(mq32.pop_back());
            end
            if (mq20[LAT-1] == -1 || rdy) begin
                mq20.push_front(val ? pop(data, mode, 20) : -1);
                void'(mq20.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (srst) begin
            chk("rst_val32", 32'(bus32.data_val_o), 32'd0);
            chk("rst_data32", 32'(bus32.data_o), 32'd0);
            chk("rst_val20", 32'(bus20.data_val_o), 32'd0);
        end else begin
            e32 = mq32[LAT-1];
            e20 = mq20[LAT-1];
            chk("val32", 32'(bus32.data_val_o), 32'(e32 != -1));
            if (e32 != -1) chk("data32", 32'(bus32.data_o), 32'(e32));
            chk("ready32", 32'(bus32.data_ready_o), 32'((e32 == -1) || rdy));
            chk("val20", 32'(bus20.data_val_o), 32'(e20 != -1));
            if (e20 != -1) chk("data20", 32'(bus20.data_o), 32'(e20));
            chk("ready20", 32'(bus20.data_ready_o), 32'((e20 == -1) || rdy));
        end
    end

    initial begin
        repeat (2) step();
        srst = 1'b0;
        @(negedge clk);
        chk("init_ready32", 32'(bus32.data_ready_o), 32'd1);
        chk("init_val32", 32'(bus32.data_val_o), 32'd0);
        chk("init_data32", 32'(bus32.data_o), 32'd0);
        chk("init_ready20", 32'(bus20.data_ready_o), 32'd1);
        idle(2);

        dir3(32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 32'h8000_0001, 1'b0,
             32, 32, 2, 20, 20, 1);
        idle(4);
        // Padding: 20-bit instance must see 0 and 20, never 24.
        dir3(32'h000F_FFFF, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0,
             12, 32, 0, 0, 20, 0);
        idle(4);

        // Back-pressure with a fourth word waiting during the stall.
        rdy = 1'b1; val = 1'b1; mode = 1'b0;
        data = 32'h0000_000F; step();
        data = 32'h0000_00FF; step();
        data = 32'h0000_0FFF; step();
        data = 32'hFFFF_0000; mode = 1'b1; rdy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(bus32.data_o), 32'd4);
            chk("bp_hold_val", 32'(bus32.data_val_o), 32'd1);
            chk("bp_hold_ready", 32'(bus32.data_ready_o), 32'd0);
            step();
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus32.data_ready_o), 32'd1);
        chk("bp_release_data", 32'(bus32.data_o), 32'd4);
        step();
        val = 1'b0; data = 'x;
        @(negedge clk); chk("bp_out1", 32'(bus32.data_o), 32'd8);
        @(negedge clk); chk("bp_out2", 32'(bus32.data_o), 32'd12);
        @(negedge clk); chk("bp_out3", 32'(bus32.data_o), 32'd16);
        chk("bp_out3_20", 32'(bus20.data_o), 32'd16);
        idle(4);

        // Bubbles keep their slots.
        mode = 1'b0;
        for (int j = 0; j < 6; j++) begin
            val  = (j == 0 || j == 2);
            data = (j == 0) ? 32'h1 : ((j == 2) ? 32'h3 : 'x);
            step();
            if (j >= 2) begin
                @(negedge clk);
                chk("bub_val32", 32'(bus32.data_val_o), 32'(bub_v[j-2]));
                chk("bub_val20", 32'(bus20.data_val_o), 32'(bub_v[j-2]));
                if (bub_v[j-2] == 1) chk("bub_data32", 32'(bus32.data_o), 32'(bub_d[j-2]));
            end
        end
        idle(4);

        // Asynchronous reset with two words in flight.
        val = 1'b1; mode = 1'b0;
        data = 32'h0000_0007; step();
        data = 32'h0000_003F; step();
        val = 1'b0; data = 'x;
        #2 srst = 1'b1;
        #1;
        chk("async_rst_val32", 32'(bus32.data_val_o), 32'd0);
        chk("async_rst_val20", 32'(bus20.data_val_o), 32'd0);
        step();
        srst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_val32", 32'(bus32.data_val_o), 32'd0);
        end
        idle(2);

        // Random traffic with random back-pressure.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            val  = ($urandom_range(0, 99) < 75);
            data = val ? 32'($urandom) : 'x;
            mode = 1'($urandom_range(0, 1));
            rdy  = ($urandom_range(0, 99) < 70);
            step();
            cyc++;
        end
        chk("rand_accept_budget", 32'(n_acc >= 10000), 32'd1);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
